// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
//   state_t    : arbiter sequencer states (IDLE, LAUNCH, WAIT, RESP)
//   WIDTH_DEF  : default operand/result width, matching the divider
//   TIMEOUT_DEF: default watchdog limit in cycles (only used with DIVARB_TIMEOUT_EN)
//   DIV0_QUOT  : all-ones quotient reported on divide-by-zero; it is wider than
//                any supported WIDTH and is truncated at the point of use
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  localparam int WIDTH_DEF   = 1025;
  localparam int TIMEOUT_DEF = 4096;
  localparam int QUOT_MAX_W  = 4096;

  localparam logic [QUOT_MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// rr_picker: combinational two-way round-robin selection.
// Ports:
//   req  in  2 : level requests
//   last in  1 : index of the requester served most recently
//   pick out 2 : one-hot winner, zero when nothing is requested
// A lone requester always wins; on a tie the requester not served last wins.
module rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one nonrestoring divider between the n0prime unit
// (requester 0) and the R^2 mod n precompute unit (requester 1).
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req[1:0]                  : level requests
//   dividend0/divisor0        : operands of requester 0
//   dividend1/divisor1        : operands of requester 1
//   gnt[1:0]                  : one-hot grant, held until the done pulse
//   done[1:0]                 : one-cycle completion pulse to the granted requester
//   quotient, remainder, err  : result of the last completed operation
//   div_start, div_q, div_m   : start pulse and registered operands to the divider
//   div_done, div_qout, div_r : completion and results from the divider
// Optional feature: define DIVARB_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT cycles that ends a hung division with err=1 and zero results.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_qout,
  input  logic [WIDTH-1:0] div_r
);

  if (NREQ != 2) begin : g_nreq_chk
    $error("div_arbiter: NREQ must be 2");
  end
  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("div_arbiter: TIMEOUT must be at least 2");
  end
  if (WIDTH > QUOT_MAX_W) begin : g_width_chk
    $error("div_arbiter: WIDTH exceeds QUOT_MAX_W");
  end

  state_t           state;
  logic             last;
  logic [1:0]       pick;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

`ifdef DIVARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;
`endif

  rr_picker u_picker (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  // Operands of the winner; only consumed in IDLE, so later changes are ignored.
  assign sel_dividend = pick[1] ? dividend1 : dividend0;
  assign sel_divisor  = pick[1] ? divisor1  : divisor0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= '0;
      done      <= '0;
      div_start <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_q     <= '0;
      div_m     <= '0;
`ifdef DIVARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      done      <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= pick;
            div_q <= sel_dividend;
            div_m <= sel_divisor;
            if (sel_divisor == '0) begin
              // Divide-by-zero is answered locally; the divider is never started.
              quotient  <= WIDTH'(DIV0_QUOT);
              remainder <= sel_dividend;
              err       <= 1'b1;
              state     <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
`ifdef DIVARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            quotient  <= div_qout;
            remainder <= div_r;
            err       <= 1'b0;
            state     <= RESP;
          end
`ifdef DIVARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          done  <= gnt;
          last  <= gnt[1];
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: self-checking bench for div_arbiter with a behavioural
// divider of programmable latency and a requester-level reference model.
module tb_div_arbiter;

  localparam int W  = 1025;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   req = '0;
  logic [W-1:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
  logic [1:0]   gnt, done;
  logic [W-1:0] quotient, remainder, div_q, div_m;
  logic         err, div_start;
  logic         div_done = 1'b0;
  logic [W-1:0] div_qout = '0, div_r = '0;

  int tests_run = 0;
  int tests_failed = 0;

  // Divider model state
  int           dm_lat = 5;
  bit           dm_hang = 1'b0;
  bit           dm_busy = 1'b0;
  int           dm_cnt = 0;
  int           start_cnt = 0;
  logic [W-1:0] dm_a, dm_b;

  // Reference: index of the requester served most recently (reset: 1)
  int ref_last = 1;

  div_arbiter #(.WIDTH(W), .NREQ(2), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .gnt       (gnt),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err),
    .div_start (div_start),
    .div_q     (div_q),
    .div_m     (div_m),
    .div_done  (div_done),
    .div_qout  (div_qout),
    .div_r     (div_r)
  );

  always #5 clk = ~clk;

  // Behavioural divider: captures operands on start, answers dm_lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (div_done) div_done = 1'b0;
      if (dm_busy) begin
        if (dm_cnt > 1) dm_cnt--;
        else begin
          dm_busy = 1'b0;
          if (!dm_hang) begin
            div_done = 1'b1;
            div_qout = dm_a / dm_b;
            div_r    = dm_a % dm_b;
          end
        end
      end
      if (div_start) begin
        start_cnt++;
        dm_busy = 1'b1;
        dm_cnt  = dm_lat;
        dm_a    = div_q;
        dm_b    = div_m;
      end
    end
  end

  function automatic logic [W-1:0] rand_wide(input int words);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < words; k++) v = (v << 32) | {{(W-32){1'b0}}, $urandom()};
    return v;
  endfunction

  // Winner by the round-robin rule: a lone requester wins, a tie goes to the
  // requester that was not served last.
  function automatic int ref_winner(input logic [1:0] r, input int last_served);
    if (r == 2'b11) return 1 - last_served;
    return r[1] ? 1 : 0;
  endfunction

  // Waits for a done pulse; the first negedge observed is the one right after
  // the IDLE sampling edge, so n counts cycles from that edge.
  task automatic wait_done(input int bound, output int n, output logic [1:0] d,
                           output logic [1:0] g1, output bit started);
    n = 0; d = '0; g1 = '0; started = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (div_start) started = 1'b1;
      if (i == 1) g1 = gnt;
      if (done != '0) begin
        n = i;
        d = done;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt, done, div_start, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl gnt=%b done=%b start=%b err=%b expected all 0", gnt, done, div_start, err);
    end
    tests_run++;
    if (quotient !== '0 || remainder !== '0 || div_q !== '0 || div_m !== '0) begin
      tests_failed++;
      $display("FAIL reset_data q=%0h r=%0h dq=%0h dm=%0h expected 0",
               quotient[127:0], remainder[127:0], div_q[127:0], div_m[127:0]);
    end
    rst_n = 1'b1;
    ref_last = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int n; logic [1:0] d, g1; bit st;
    dm_lat = 5;
    dividend0 = W'(64'h1_0000_0000);
    divisor0  = W'(4'hD);
    req = 2'b01;
    wait_done(60, n, d, g1, st);
    req = 2'b00;
    ref_last = 0;
    tests_run++;
    if (g1 !== 2'b01) begin
      tests_failed++; $display("FAIL single_gnt got %b expected 01", g1);
    end
    tests_run++;
    if (n != 8 || d !== 2'b01) begin
      tests_failed++; $display("FAIL single_done_time cycle=%0d done=%b expected cycle 8 done 01", n, d);
    end
    tests_run++;
    if (quotient !== W'(32'h13B13B13) || remainder !== W'(4'h9) || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result q=%0h r=%0h err=%b expected 13b13b13 9 0", quotient[127:0], remainder[127:0], err);
    end
    tests_run++;
    if (gnt !== 2'b00) begin
      tests_failed++; $display("FAIL single_gnt_clear got %b expected 00", gnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention;
    int n; logic [1:0] d, g1; bit st;
    logic [W-1:0] a0, b0, a1, b1;
    dm_lat = $urandom_range(1, 8);
    a0 = rand_wide(20); b0 = rand_wide(6) | W'(1);
    a1 = rand_wide(25); b1 = rand_wide(3) | W'(1);
    dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
    // Requester 0 was served last, so force a clean tie-break via reset state.
    ref_last = 1;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    req = 2'b11;
    wait_done(60, n, d, g1, st);
    req = 2'b10;
    tests_run++;
    if (g1 !== 2'b01 || d !== 2'b01 || n != dm_lat + 3) begin
      tests_failed++;
      $display("FAIL contention_first gnt=%b done=%b cycle=%0d expected 01 01 %0d", g1, d, n, dm_lat + 3);
    end
    tests_run++;
    if (quotient !== a0 / b0 || remainder !== a0 % b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_res0 q=%0h r=%0h expected %0h %0h", quotient[127:0], remainder[127:0],
               (a0 / b0) & W'({128{1'b1}}), (a0 % b0) & W'({128{1'b1}}));
    end
    wait_done(60, n, d, g1, st);
    req = 2'b00;
    tests_run++;
    if (g1 !== 2'b10 || d !== 2'b10 || n != dm_lat + 3) begin
      tests_failed++;
      $display("FAIL contention_second gnt=%b done=%b cycle=%0d expected 10 10 %0d", g1, d, n, dm_lat + 3);
    end
    tests_run++;
    if (quotient !== a1 / b1 || remainder !== a1 % b1) begin
      tests_failed++;
      $display("FAIL contention_res1 q=%0h r=%0h", quotient[127:0], remainder[127:0]);
    end
    ref_last = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness;
    int n; logic [1:0] d, g1; bit st;
    int exp_w, prev_w;
    logic [W-1:0] a, b;
    prev_w = -1;
    dividend0 = rand_wide(10); divisor0 = rand_wide(2) | W'(1);
    dividend1 = rand_wide(12); divisor1 = rand_wide(4) | W'(1);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_w = ref_winner(2'b11, ref_last);
      a = exp_w ? dividend1 : dividend0;
      b = exp_w ? divisor1 : divisor0;
      wait_done(60, n, d, g1, st);
      tests_run++;
      if (d !== (2'b01 << exp_w) || g1 !== (2'b01 << exp_w) || n != dm_lat + 3 || exp_w == prev_w) begin
        tests_failed++;
        $display("FAIL fairness_op%0d gnt=%b done=%b cycle=%0d expected winner %0d cycle %0d",
                 k, g1, d, n, exp_w, dm_lat + 3);
      end
      tests_run++;
      if (quotient !== a / b || remainder !== a % b) begin
        tests_failed++;
        $display("FAIL fairness_res%0d q=%0h r=%0h", k, quotient[127:0], remainder[127:0]);
      end
      ref_last = exp_w;
      prev_w = exp_w;
      // The served requester keeps requesting with fresh operands.
      if (exp_w == 0) begin dividend0 = rand_wide(9); divisor0 = rand_wide(2) | W'(1); end
      else begin dividend1 = rand_wide(11); divisor1 = rand_wide(3) | W'(1); end
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div0;
    int n; logic [1:0] d, g1; bit st;
    int starts;
    starts = start_cnt;
    dividend1 = W'(16'h1234);
    divisor1  = '0;
    req = 2'b10;
    wait_done(60, n, d, g1, st);
    req = 2'b00;
    ref_last = 1;
    tests_run++;
    if (n != 2 || d !== 2'b10 || g1 !== 2'b10) begin
      tests_failed++;
      $display("FAIL div0_done cycle=%0d done=%b gnt=%b expected 2 10 10", n, d, g1);
    end
    tests_run++;
    if (quotient !== {W{1'b1}} || remainder !== W'(16'h1234) || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL div0_result q=%0h r=%0h err=%b expected all-ones 1234 1",
               quotient[127:0], remainder[127:0], err);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (st || start_cnt != starts) begin
      tests_failed++;
      $display("FAIL div0_no_start starts=%0d expected %0d", start_cnt - starts, 0);
    end
  endtask

  task automatic test_random;
    int n; logic [1:0] d, g1; bit st;
    logic [1:0] r;
    int exp_w;
    logic [W-1:0] a, b, eq, er;
    logic e_err;
    int fails;
    for (int k = 0; k < 12; k++) begin
      fails = 0;
      dm_lat = $urandom_range(1, 9);
      r = 2'($urandom_range(1, 3));
      dividend0 = rand_wide($urandom_range(1, 32));
      dividend1 = rand_wide($urandom_range(1, 32));
      divisor0  = ($urandom_range(0, 4) == 0) ? '0 : rand_wide($urandom_range(1, 8)) | W'(1);
      divisor1  = ($urandom_range(0, 4) == 0) ? '0 : rand_wide($urandom_range(1, 8)) | W'(1);
      exp_w = ref_winner(r, ref_last);
      a = exp_w ? dividend1 : dividend0;
      b = exp_w ? divisor1 : divisor0;
      if (b == '0) begin eq = {W{1'b1}}; er = a; e_err = 1'b1; end
      else begin eq = a / b; er = a % b; e_err = 1'b0; end
      req = r;
      wait_done(60, n, d, g1, st);
      req = 2'b00;
      tests_run++;
      if (d !== (2'b01 << exp_w) || g1 !== (2'b01 << exp_w) ||
          n != ((b == '0) ? 2 : dm_lat + 3) || st != (b != '0)) begin
        tests_failed++;
        $display("FAIL random%0d_timing req=%b gnt=%b done=%b cycle=%0d start=%b expected winner %0d",
                 k, r, g1, d, n, st, exp_w);
      end
      tests_run++;
      if (quotient !== eq || remainder !== er || err !== e_err) begin
        tests_failed++;
        $display("FAIL random%0d_result q=%0h r=%0h err=%b expected %0h %0h %b", k,
                 quotient[127:0], remainder[127:0], err, eq[127:0], er[127:0], e_err);
      end
      ref_last = exp_w;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int n; logic [1:0] d, g1; bit st;
    int spurious;
    logic [W-1:0] a, b;
    dm_lat = 10;
    dividend0 = rand_wide(8); divisor0 = rand_wide(2) | W'(1);
    req = 2'b01;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    tests_run++;
    if ({gnt, done, div_start, err} !== 6'b0 || quotient !== '0 || remainder !== '0 ||
        div_q !== '0 || div_m !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs gnt=%b done=%b start=%b err=%b q=%0h dq=%0h expected 0",
               gnt, done, div_start, err, quotient[127:0], div_q[127:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_last = 1;
    spurious = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done != '0 || gnt != '0 || div_start) spurious++;
    end
    tests_run++;
    if (spurious != 0 || dm_busy) begin
      tests_failed++;
      $display("FAIL reset_mid_stale activity=%0d busy=%b expected 0 0", spurious, dm_busy);
    end
    dm_lat = 4;
    a = rand_wide(16); b = rand_wide(5) | W'(1);
    dividend0 = a; divisor0 = b;
    dividend1 = rand_wide(16); divisor1 = rand_wide(5) | W'(1);
    req = 2'b11;
    wait_done(60, n, d, g1, st);
    req = 2'b00;
    tests_run++;
    if (d !== 2'b01 || n != 7 || quotient !== a / b || remainder !== a % b) begin
      tests_failed++;
      $display("FAIL reset_mid_next done=%b cycle=%0d q=%0h expected 01 7 %0h",
               d, n, quotient[127:0], (a / b) & W'({128{1'b1}}));
    end
    ref_last = 0;
    repeat (2) @(negedge clk);
  endtask

`ifdef DIVARB_TIMEOUT_EN
  task automatic test_timeout;
    int n; logic [1:0] d, g1; bit st;
    dm_hang = 1'b1;
    dividend1 = rand_wide(6); divisor1 = rand_wide(2) | W'(1);
    req = 2'b10;
    wait_done(80, n, d, g1, st);
    req = 2'b00;
    tests_run++;
    if (d !== 2'b10 || n != TO + 3) begin
      tests_failed++;
      $display("FAIL timeout_done done=%b cycle=%0d expected 10 %0d", d, n, TO + 3);
    end
    tests_run++;
    if (err !== 1'b1 || quotient !== '0 || remainder !== '0) begin
      tests_failed++;
      $display("FAIL timeout_result err=%b q=%0h r=%0h expected 1 0 0", err, quotient[127:0], remainder[127:0]);
    end
    repeat (4) @(negedge clk);
    dm_hang = 1'b0;
    ref_last = 1;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_fairness;
    test_div0;
    test_random;
    test_reset_mid;
`ifdef DIVARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
